// File: rtl/alink_tx_sched_pkg.sv
// Shared lane count, task size, counter widths and FSM encodings for the Alink TX scheduler.
// Constant definitions only.
package alink_tx_sched_pkg;

    localparam int PHY_NUM       = 32;
    localparam int PTR_W         = 5;
    localparam int TX_TASKID_LEN = 1;
    localparam int TX_DATA_LEN   = 19;
    localparam int TASK_WORDS    = TX_TASKID_LEN + TX_DATA_LEN;
    localparam int CNT_W         = 10;
    localparam int GAP_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DRAIN = 3'd5
    } sched_state_t;

    function automatic logic [31:0] lane_onehot(input logic [PTR_W-1:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/alink_tx_sched_if.sv
// CSR, TxFIFO-status and tx_phy handshake bundle for the TX scheduler.
// slave = scheduler view, master = CSR/FIFO/tx_phy side.
interface alink_tx_sched_if;
    import alink_tx_sched_pkg::*;

    logic                reg_en;
    logic                reg_flush;
    logic [PHY_NUM-1:0]  reg_phy_mask;
    logic [GAP_W-1:0]    reg_gap;
    logic [PHY_NUM-1:0]  phy_busy;
    logic [CNT_W-1:0]    txfifo_cnt;
    logic                tx_phy_start;
    logic [31:0]         tx_phy_sel;
    logic                tx_phy_done;
    logic                sched_busy;
    logic [31:0]         task_cnt;
    logic [PTR_W-1:0]    last_phy;

    modport slave (
        input  reg_en, reg_flush, reg_phy_mask, reg_gap, phy_busy, txfifo_cnt, tx_phy_done,
        output tx_phy_start, tx_phy_sel, sched_busy, task_cnt, last_phy
    );

    modport master (
        output reg_en, reg_flush, reg_phy_mask, reg_gap, phy_busy, txfifo_cnt, tx_phy_done,
        input  tx_phy_start, tx_phy_sel, sched_busy, task_cnt, last_phy
    );

endinterface

// File: rtl/alink_tx_sched_rr_arb.sv
// Rotating-priority picker: first set request after i_ptr, wrapping modulo N.
// Purely combinational, zero latency; no handshake.
module alink_tx_sched_rr_arb #(
    parameter int N  = 32,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_gnt_vld,
    output logic [IW-1:0] o_gnt_idx
);

    logic [2*N-1:0] w_dbl;

    // Lower copy is masked at and below the pointer; the upper copy supplies the wrap-around.
    assign w_dbl = {i_req, i_req};

    always_comb begin
        o_gnt_vld = |i_req;
        o_gnt_idx = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (w_dbl[i] && (i > int'(i_ptr))) begin
                o_gnt_idx = IW'(i % N);
            end
        end
    end

endmodule

// File: rtl/alink_tx_sched.sv
// Round-robin TX task scheduler: gates on a whole task in TxFIFO, grants one PHY lane, waits done, inserts gap.
// Ready in IDLE at t -> tx_phy_start at t+2; done at d (gap 0) -> earliest next start at d+3.
module alink_tx_sched
    import alink_tx_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alink_tx_sched_if.slave   bus
);

    sched_state_t      r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_last_phy;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [31:0]       r_task_cnt;
    logic              r_start;
    logic [31:0]       r_sel;

    logic [PHY_NUM-1:0] w_elig;
    logic               w_ready;
    logic               w_gnt_vld;
    logic [PTR_W-1:0]   w_gnt_idx;

    assign w_elig  = bus.reg_phy_mask & ~bus.phy_busy;
    assign w_ready = bus.reg_en & ~bus.reg_flush & (|w_elig)
                   & (bus.txfifo_cnt >= CNT_W'(TASK_WORDS));

    alink_tx_sched_rr_arb #(.N(PHY_NUM), .IW(PTR_W)) u_arb (
        .i_req     (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= PTR_W'(PHY_NUM - 1);
            r_last_phy <= '0;
            r_gap_cnt  <= '0;
            r_task_cnt <= '0;
            r_start    <= 1'b0;
            r_sel      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ready) r_state <= ST_GRANT;
                end
                ST_GRANT: begin
                    // Lane choice is final here; later mask/busy changes do not recall the task.
                    if (!bus.reg_flush && w_gnt_vld) begin
                        r_last_phy <= w_gnt_idx;
                        r_ptr      <= w_gnt_idx;
                        r_start    <= 1'b1;
                        r_sel      <= lane_onehot(w_gnt_idx);
                        r_state    <= ST_START;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    r_start <= 1'b0;
                    r_sel   <= '0;
                    r_state <= bus.reg_flush ? ST_DRAIN : ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.tx_phy_done) begin
                        r_task_cnt <= r_task_cnt + 32'd1;
                        if (bus.reg_gap != '0) begin
                            r_gap_cnt <= bus.reg_gap;
                            r_state   <= ST_GAP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (bus.reg_flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_GAP: begin
                    if (bus.reg_flush || r_gap_cnt == GAP_W'(1)) r_state <= ST_IDLE;
                    else r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                end
                ST_DRAIN: begin
                    if (bus.tx_phy_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_phy_start = r_start;
    assign bus.tx_phy_sel   = r_sel;
    assign bus.sched_busy   = (r_state != ST_IDLE);
    assign bus.task_cnt     = r_task_cnt;
    assign bus.last_phy     = r_last_phy;

endmodule

// File: tb/tb_alink_tx_sched.sv
// Directed bench for alink_tx_sched: expected lane selects queued at stimulus time, popped on each start.
module tb_alink_tx_sched;
    import alink_tx_sched_pkg::*;

    logic clk;
    logic rst;
    alink_tx_sched_if bus ();

    alink_tx_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int starts   = 0;
    logic [31:0] sel_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every start pulse must match the next queued lane select.
    initial forever begin
        @(negedge clk);
        if (bus.tx_phy_start === 1'b1) begin
            starts++;
            check("sb_start_expected", 32'(sel_q.size() != 0), 32'd1);
            if (sel_q.size() != 0) check("sb_sel", bus.tx_phy_sel, sel_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget, output int s);
        s = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.tx_phy_start === 1'b1) begin
                s = cyc;
                break;
            end
            tick(1);
        end
        check("start_within_budget", 32'(s >= 0), 32'd1);
    endtask

    task automatic do_task(input int dly, input bit last, output int s, output int d);
        wait_start(200, s);
        if (last) bus.reg_en = 1'b0;
        tick(dly);
        bus.tx_phy_done = 1'b1;
        d = cyc;
        tick(1);
        bus.tx_phy_done = 1'b0;
    endtask

    initial begin
        int s, d, t, prev_d, n0, exp_tc;
        bit all_busy;

        rst               = 1'b1;
        bus.reg_en        = 1'b0;
        bus.reg_flush     = 1'b0;
        bus.reg_phy_mask  = '0;
        bus.reg_gap       = '0;
        bus.phy_busy      = '0;
        bus.txfifo_cnt    = '0;
        bus.tx_phy_done   = 1'b0;
        exp_tc            = 0;
        tick(3);
        check("rst_start", 32'(bus.tx_phy_start), 32'd0);
        check("rst_sel", bus.tx_phy_sel, 32'd0);
        check("rst_busy", 32'(bus.sched_busy), 32'd0);
        check("rst_task_cnt", bus.task_cnt, 32'd0);
        check("rst_last_phy", 32'(bus.last_phy), 32'd0);
        rst = 1'b0;
        tick(2);

        // 1: alternating lanes 0 and 2, back-to-back with gap 0
        bus.reg_phy_mask = 32'h5;
        bus.txfifo_cnt   = CNT_W'(TASK_WORDS);
        sel_q.push_back(32'h1); sel_q.push_back(32'h4);
        sel_q.push_back(32'h1); sel_q.push_back(32'h4);
        bus.reg_en = 1'b1;
        t = cyc;
        prev_d = 0;
        for (int k = 0; k < 4; k++) begin
            do_task(10, k == 3, s, d);
            if (k == 0) check("t1_first_latency", 32'(s - t), 32'd2);
            else        check("t1_done_to_start", 32'(s - prev_d), 32'd3);
            prev_d = d;
        end
        exp_tc += 4;
        tick(2);
        check("t1_task_cnt", bus.task_cnt, 32'(exp_tc));
        check("t1_last_phy", 32'(bus.last_phy), 32'd2);

        // 2: one word short of a task holds the scheduler off
        bus.txfifo_cnt = CNT_W'(TASK_WORDS - 1);
        bus.reg_en = 1'b1;
        n0 = starts;
        tick(50);
        check("t2_no_start_short", 32'(starts - n0), 32'd0);
        check("t2_idle_short", 32'(bus.sched_busy), 32'd0);
        sel_q.push_back(32'h1);
        bus.txfifo_cnt = CNT_W'(TASK_WORDS);
        t = cyc;
        do_task(10, 1'b1, s, d);
        exp_tc += 1;
        check("t2_start_latency", 32'(s - t), 32'd2);
        tick(2);

        // 3: busy lane 1 skipped, pointer wraps 3 -> 0
        bus.reg_phy_mask = 32'hF;
        bus.phy_busy     = 32'h2;
        sel_q.push_back(32'h4); sel_q.push_back(32'h8); sel_q.push_back(32'h1);
        bus.reg_en = 1'b1;
        do_task(4, 1'b0, s, d);
        check("t3_last_phy_skip", 32'(bus.last_phy), 32'd2);
        do_task(4, 1'b0, s, d);
        do_task(4, 1'b1, s, d);
        exp_tc += 3;
        check("t3_last_phy_wrap", 32'(bus.last_phy), 32'd0);
        bus.phy_busy = '0;
        tick(2);

        // 4: gap of 5 cycles after done
        bus.reg_phy_mask = 32'h5;
        bus.reg_gap      = 16'd5;
        sel_q.push_back(32'h4); sel_q.push_back(32'h1);
        bus.reg_en = 1'b1;
        do_task(6, 1'b0, s, d);
        all_busy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (bus.sched_busy !== 1'b1) all_busy = 1'b0;
            if (k < 5) tick(1);
        end
        check("t4_busy_in_gap", 32'(all_busy), 32'd1);
        prev_d = d;
        do_task(6, 1'b1, s, d);
        exp_tc += 2;
        check("t4_gap_to_start", 32'(s - prev_d), 32'd8);
        tick(10);
        bus.reg_gap = '0;
        check("t4_task_cnt", bus.task_cnt, 32'(exp_tc));

        // 5: flush pulse in WAIT drains without counting; held flush blocks starts
        sel_q.push_back(32'h4);
        bus.reg_en = 1'b1;
        wait_start(200, s);
        tick(3);
        bus.reg_flush = 1'b1;
        tick(1);
        bus.reg_flush = 1'b0;
        n0 = starts;
        tick(10);
        check("t5_busy_in_drain", 32'(bus.sched_busy), 32'd1);
        tick(8);
        bus.reg_flush = 1'b1;
        tick(1);
        bus.tx_phy_done = 1'b1;
        tick(1);
        bus.tx_phy_done = 1'b0;
        tick(2);
        check("t5_drain_no_count", bus.task_cnt, 32'(exp_tc));
        check("t5_idle_after_drain", 32'(bus.sched_busy), 32'd0);
        tick(3);
        bus.tx_phy_done = 1'b1;
        tick(1);
        bus.tx_phy_done = 1'b0;
        tick(15);
        check("t5_no_start_flush", 32'(starts - n0), 32'd0);
        check("t5_stray_done_ignored", bus.task_cnt, 32'(exp_tc));
        sel_q.push_back(32'h1);
        bus.reg_flush = 1'b0;
        do_task(5, 1'b1, s, d);
        exp_tc += 1;
        tick(2);
        check("t5_task_cnt", bus.task_cnt, 32'(exp_tc));

        // 6: asynchronous reset during START
        bus.reg_en = 1'b1;
        wait_start(200, s);
        #2 rst = 1'b1;
        #1;
        check("t6_start_async", 32'(bus.tx_phy_start), 32'd0);
        check("t6_sel_async", bus.tx_phy_sel, 32'd0);
        check("t6_busy_async", 32'(bus.sched_busy), 32'd0);
        check("t6_task_cnt_cleared", bus.task_cnt, 32'd0);
        tick(2);
        sel_q.push_back(32'h1);
        rst = 1'b0;
        do_task(5, 1'b1, s, d);
        tick(2);
        check("t6_first_lane", 32'(bus.last_phy), 32'd0);
        check("t6_task_cnt", bus.task_cnt, 32'd1);

        tick(5);
        check("sb_queue_drained", 32'(sel_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
